// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter for the host UART link.
// One byte is accepted per `out` strobe while idle. It goes onto `tx` as a
// start bit, eight data bits LSB first, and one stop bit. Each bit lasts
// exactly CLK_DIV clock cycles. `busy` covers the whole frame. Both outputs
// come straight from flops.
module uart_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] data,
    input  logic       out,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             bit_end_s;

    // The last cycle of a bit is reached when the divider sits at CLK_DIV-1.
    assign bit_end_s = (div_q == DIV_LAST);

    // Divider next value: wrap at the bit boundary so no bit is ever stretched.
    always_comb begin
        div_d = div_q;
        if (bit_end_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Frame sequencer: the state, divider, bit index, shift register and both line outputs.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_q  <= '0;
                    bit_q  <= 3'd0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (out) begin
                        // The start bit and busy are both visible from the accepting edge.
                        shift_q <= data;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    div_q <= div_d;
                    if (bit_end_s) begin
                        state_q <= S_DATA;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end else begin
                        tx_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    div_q <= div_d;
                    if (bit_end_s) begin
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // shift_q[1] is the bit that becomes the LSB after this shift.
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        tx_q <= tx_q;
                    end
                end
                S_STOP: begin
                    div_q <= div_d;
                    tx_q  <= 1'b1;
                    if (bit_end_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    div_q   <= '0;
                    bit_q   <= 3'd0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx.
// Two instances share the clock and reset: one uses CLK_DIV=4 and one uses
// CLK_DIV=2. A frame-level model predicts busy/tx from the acceptance edge
// and the byte, using bit = offset / CLK_DIV. A receiver decodes the
// CLK_DIV=4 line back into bytes.
module tb_uart_tx;

    localparam int D4 = 4;
    localparam int D2 = 2;

    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] data4;
    logic [7:0] data2;
    logic       out4;
    logic       out2;
    logic       busy4;
    logic       tx4;
    logic       busy2;
    logic       tx2;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .nRst(nRst), .data(data4), .out(out4), .busy(busy4), .tx(tx4)
    );

    uart_tx #(.CLK_DIV(2)) dut2 (
        .clk(clk), .nRst(nRst), .data(data2), .out(out2), .busy(busy2), .tx(tx2)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_en   = 1'b0;
    int         cyc      = 0;

    bit         m_act[2]    = '{1'b0, 1'b0};
    int         m_e[2]      = '{0, 0};
    logic [7:0] m_byte[2]   = '{8'h00, 8'h00};
    logic       exp_busy[2] = '{1'b0, 1'b0};
    logic       exp_tx[2]   = '{1'b1, 1'b1};

    logic [7:0] rx_q[$];
    bit         rx_on  = 1'b0;
    int         rx_cnt = 0;
    int         rx_idx = 0;
    logic [7:0] rx_sh  = 8'h00;

    logic [9:0] seq;
    int         bc;
    int         sent;
    int         nloop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line level at frame bit i: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
        else return 1'b1;
    endfunction

    function automatic logic get_tx(input int k);
        return (k == 0) ? tx4 : tx2;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? busy4 : busy2;
    endfunction

    task automatic model_step(input int k, input int d, input logic o, input logic [7:0] dt);
        int off;
        if (nRst !== 1'b1) begin
            m_act[k] = 1'b0;
        end else if (!exp_busy[k] && o === 1'b1) begin
            m_act[k]  = 1'b1;
            m_e[k]    = cyc;
            m_byte[k] = dt;
        end
        off = cyc - m_e[k];
        if (m_act[k] && off < 10 * d) begin
            exp_busy[k] = 1'b1;
            exp_tx[k]   = frame_bit(m_byte[k], off / d);
        end else begin
            m_act[k]    = 1'b0;
            exp_busy[k] = 1'b0;
            exp_tx[k]   = 1'b1;
        end
    endtask

    // Reference model advances on every rising edge, using the inputs the DUT sampled there.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, D4, out4, data4);
            model_step(1, D2, out2, data2);
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("tx4",   tx4,   exp_tx[0]);
                chk("busy4", busy4, exp_busy[0]);
                chk("tx2",   tx2,   exp_tx[1]);
                chk("busy2", busy2, exp_busy[1]);
            end
        end
    end

    // Receiver on the CLK_DIV=4 line, sampling in the middle of each bit.
    initial begin
        forever begin
            @(negedge clk);
            if (nRst !== 1'b1) begin
                rx_on = 1'b0;
            end else if (rx_on) begin
                rx_cnt++;
                if (rx_cnt == D4 * (rx_idx + 1) + D4 / 2) begin
                    if (rx_idx < 8) begin
                        rx_sh = {tx4, rx_sh[7:1]};
                        rx_idx++;
                    end else begin
                        chk("rx_stop", tx4, 1'b1);
                        rx_q.push_back(rx_sh);
                        rx_on = 1'b0;
                    end
                end
            end else if (tx4 === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
                rx_idx = 0;
            end
        end
    end

    // Call at posedge+1: one-cycle strobe, then data is scrambled.
    task automatic pulse(input int k, input logic [7:0] b);
        if (k == 0) begin out4 = 1'b1; data4 = b; end
        else        begin out2 = 1'b1; data2 = b; end
        @(posedge clk); #1;
        if (k == 0) begin out4 = 1'b0; data4 = 8'($urandom); end
        else        begin out2 = 1'b0; data2 = 8'($urandom); end
    endtask

    task automatic wait_idle(input int k, input int budget, input string name);
        int n;
        n = 0;
        while (get_busy(k) === 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, get_busy(k), 1'b0);
    endtask

    // Sends one byte and samples tx at the start of each bit. It also counts busy-high cycles.
    task automatic capture(input int k, input logic [7:0] b, output logic [9:0] s, output int cnt);
        int d;
        d = (k == 0) ? D4 : D2;
        s = 10'h000;
        pulse(k, b);
        s[0] = get_tx(k);
        cnt = (get_busy(k) === 1'b1) ? 1 : 0;
        for (int c = 1; c < 12 * d; c++) begin
            @(posedge clk); #1;
            if ((c % d) == 0 && (c / d) < 10) s[c / d] = get_tx(k);
            if (get_busy(k) === 1'b1) cnt++;
        end
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; out4 = 1'b1; out2 = 1'b1; data4 = 8'hFF; data2 = 8'hFF;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Reset held with a pending strobe: the line stays idle.
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx4",   tx4,   1'b1);
            chk("rst_busy4", busy4, 1'b0);
            chk("rst_tx2",   tx2,   1'b1);
            chk("rst_busy2", busy2, 1'b0);
            @(posedge clk); #1;
        end
        nRst = 1'b1; out4 = 1'b0; out2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_tx4",   tx4,   1'b1);
        chk("idle_busy4", busy4, 1'b0);

        // Single frame, 8'hA5, CLK_DIV=4.
        rx_q.delete();
        capture(0, 8'hA5, seq, bc);
        chk("a5_seq",  seq, 10'b1101001010);
        chk("a5_busy", bc,  40);
        chk("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_rx", rx_q[0], 8'hA5);

        // Divider lower bound, CLK_DIV=2, 8'h01.
        capture(1, 8'h01, seq, bc);
        chk("div2_seq",  seq, 10'b1000000010);
        chk("div2_busy", bc,  20);

        // Strobe during a frame is ignored and not queued.
        rx_q.delete();
        pulse(0, 8'h3C);
        repeat (8) @(posedge clk);
        #1;
        out4 = 1'b1; data4 = 8'h00;
        @(posedge clk); #1;
        out4 = 1'b0;
        wait_idle(0, 100, "ign_idle");
        repeat (20) @(posedge clk);
        #1;
        chk("ign_no2nd", busy4, 1'b0);
        chk("ign_rx_n",  rx_q.size(), 1);
        if (rx_q.size() > 0) chk("ign_rx", rx_q[0], 8'h3C);

        // Controller handshake: 16 bytes 0x00..0x0F back to back.
        rx_q.delete();
        sent = 0;
        nloop = 0;
        while (sent < 16 && nloop < 2000) begin
            @(posedge clk); #1;
            nloop++;
            if (busy4 === 1'b0 && out4 === 1'b0) begin
                out4 = 1'b1; data4 = 8'(sent); sent++;
            end else begin
                out4 = 1'b0; data4 = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        out4 = 1'b0;
        chk("b2b_sent", sent, 16);
        wait_idle(0, 100, "b2b_idle");
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_rx_n", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("b2b_rx", rx_q[i], 8'(i));

        // Reset during data bit 3 of 8'h55, then a fresh 8'hC3.
        rx_q.delete();
        pulse(0, 8'h55);
        repeat (15) @(posedge clk);
        #1;
        nRst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_tx",   tx4,   1'b1);
        chk("mid_rst_busy", busy4, 1'b0);
        nRst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_rx_n0", rx_q.size(), 0);
        pulse(0, 8'hC3);
        wait_idle(0, 100, "c3_idle");
        repeat (4) @(posedge clk);
        #1;
        chk("c3_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("c3_rx", rx_q[0], 8'hC3);

        // Random strobes, bytes and occasional resets on both instances.
        for (int i = 0; i < 800; i++) begin
            out4  = ($urandom_range(0, 7) == 0);
            out2  = ($urandom_range(0, 5) == 0);
            data4 = 8'($urandom);
            data2 = 8'($urandom);
            nRst  = ($urandom_range(0, 149) != 0);
            @(posedge clk); #1;
        end
        nRst = 1'b1; out4 = 1'b0; out2 = 1'b0;
        wait_idle(0, 100, "rnd_idle4");
        wait_idle(1, 100, "rnd_idle2");
        repeat (3) @(posedge clk);
        #1;

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
